// File: rtl/ierl78_prtyerr_pkg.sv
// Shared constants, register map offsets and slot state encoding for the
// RL78 ICE parity-error injection sequencer.
package ierl78_prtyerr_pkg;

  localparam int unsigned MAX_NSLOT = 4;
  localparam int unsigned SLOT_IW   = 2;
  localparam int unsigned ADR_W     = 16;
  localparam int unsigned DAT_W     = 16;
  localparam int unsigned HADR_W    = 32;
  localparam int unsigned CNT_W     = 8;

  localparam logic [HADR_W-1:0] ADR_OFS = 32'h0000_0000;
  localparam logic [HADR_W-1:0] CTL_OFS = 32'h0000_0010;
  localparam logic [HADR_W-1:0] STS_OFS = 32'h0000_0020;

  localparam int unsigned CTL_EN      = 0;
  localparam int unsigned CTL_CONT    = 1;
  localparam int unsigned CTL_CNT_LSB = 8;
  localparam int unsigned CTL_CNT_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2,
    ST_DONE  = 2'd3
  } slot_state_e;

  typedef struct packed {
    logic [MAX_NSLOT-1:0] armed;
    logic [MAX_NSLOT-1:0] hit;
  } sts_t;

  // Host address of a per-slot register.
  function automatic logic [HADR_W-1:0] reg_addr(input logic [HADR_W-1:0] base,
                                                 input logic [HADR_W-1:0] ofs,
                                                 input int unsigned       idx);
    return base + ofs + HADR_W'(4 * idx);
  endfunction

endpackage

// File: rtl/ierl78_prtyerr_slot.sv
// One injection slot: target address, control register, arm/fire FSM and
// the address compare that raises this slot's event request.
module ierl78_prtyerr_slot
  import ierl78_prtyerr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adr_we,
  input  logic             ctl_we,
  input  logic [DAT_W-1:0] wdata,
  input  logic [ADR_W-1:0] ma,
  input  logic             qual,
  input  logic             win,
  output logic             ev_c,
  output logic             fire_c,
  output logic             armed_c,
  output logic [ADR_W-1:0] adr_rd,
  output logic [DAT_W-1:0] ctl_rd
);

  localparam int unsigned RSV_W = DAT_W - CNT_W - 2;

  slot_state_e      state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             en_q, en_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q  <= '0;
      en_q   <= 1'b0;
      cont_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      adr_q  <= adr_d;
      en_q   <= en_d;
      cont_q <= cont_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next state; a host CTL write overrides the hardware count update
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    en_d    = en_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    case (state_q)
      ST_ARMED: if (win) state_d = ST_FIRE;
      ST_FIRE: begin
        if (cont_q) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = ST_DONE;
            en_d    = 1'b0;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end
      default: ;
    endcase
    if (adr_we) adr_d = wdata;
    if (ctl_we) begin
      en_d   = wdata[CTL_EN];
      cont_d = wdata[CTL_CONT];
      cnt_d  = wdata[CTL_CNT_MSB:CTL_CNT_LSB];
      if (!wdata[CTL_EN])                         state_d = ST_IDLE;
      else if (!((state_q == ST_ARMED) && win))   state_d = ST_ARMED;
    end
  end

  // Outputs
  always_comb begin
    ev_c    = qual && (ma == adr_q) && (state_q == ST_ARMED);
    fire_c  = (state_q == ST_FIRE);
    armed_c = en_q && (state_q == ST_ARMED);
    adr_rd  = adr_q;
    ctl_rd  = {cnt_q, {RSV_W{1'b0}}, cont_q, en_q};
  end

endmodule

// File: rtl/ierl78_prtyerr_seq.sv
// Parity-error injection sequencer: read-edge qualification, lowest-index
// arbitration across slots, sticky hit status and the host register port.
module ierl78_prtyerr_seq
  import ierl78_prtyerr_pkg::*;
#(
  parameter int unsigned NSLOT   = 4,
  parameter logic [31:0] BASEADR = 32'h0401_0000
) (
  input  logic        CLK,
  input  logic        SYSRSOUTB,
  input  logic [31:0] ICEIFA,
  input  logic [15:0] ICEDI,
  input  logic        ICEWR,
  output logic [31:0] ICEDOPB,
  input  logic [15:0] MA,
  input  logic        CPURD,
  input  logic        SVMOD,
  input  logic        FCHRAM,
  output logic        RPERR,
  output logic [1:0]  PRTYSLOT
);

  localparam logic [HADR_W-1:0] STS_A = BASEADR + STS_OFS;

  logic                 prev_rd_q, prev_rd_d;
  logic [ADR_W-1:0]     prev_ma_q, prev_ma_d;
  logic                 rperr_q, rperr_d;
  logic [SLOT_IW-1:0]   slot_q, slot_d;
  logic [MAX_NSLOT-1:0] hit_q, hit_d;

  logic                 qual_c, any_ev_c, sts_we_c;
  logic [SLOT_IW-1:0]   win_idx_c;
  logic [MAX_NSLOT-1:0] ev_c, win_c, fire_c, armed_c, adr_we_c, ctl_we_c;
  logic [ADR_W-1:0]     adr_rd [MAX_NSLOT];
  logic [DAT_W-1:0]     ctl_rd [MAX_NSLOT];
  sts_t                 sts_c;

  // Only the first cycle of a read at a given address may inject
  assign qual_c = CPURD && !(prev_rd_q && (prev_ma_q == MA)) && !SVMOD && !FCHRAM;

  always_comb begin
    adr_we_c = '0;
    ctl_we_c = '0;
    for (int unsigned i = 0; i < MAX_NSLOT; i++) begin
      adr_we_c[i] = ICEWR && (ICEIFA == reg_addr(BASEADR, ADR_OFS, i));
      ctl_we_c[i] = ICEWR && (ICEIFA == reg_addr(BASEADR, CTL_OFS, i));
    end
    sts_we_c = ICEWR && (ICEIFA == STS_A);
  end

  for (genvar g = 0; g < MAX_NSLOT; g++) begin : g_slot
    if (g < NSLOT) begin : g_on
      ierl78_prtyerr_slot u_slot (
        .clk     (CLK),
        .rst_n   (SYSRSOUTB),
        .adr_we  (adr_we_c[g]),
        .ctl_we  (ctl_we_c[g]),
        .wdata   (ICEDI),
        .ma      (MA),
        .qual    (qual_c),
        .win     (win_c[g]),
        .ev_c    (ev_c[g]),
        .fire_c  (fire_c[g]),
        .armed_c (armed_c[g]),
        .adr_rd  (adr_rd[g]),
        .ctl_rd  (ctl_rd[g])
      );
    end else begin : g_off
      assign ev_c[g]    = 1'b0;
      assign fire_c[g]  = 1'b0;
      assign armed_c[g] = 1'b0;
      assign adr_rd[g]  = '0;
      assign ctl_rd[g]  = '0;
    end
  end

  // Lowest-index priority encoder
  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    any_ev_c  = 1'b0;
    for (int unsigned i = 0; i < MAX_NSLOT; i++) begin
      if (ev_c[i] && !any_ev_c) begin
        any_ev_c     = 1'b1;
        win_c[i]     = 1'b1;
        win_idx_c    = SLOT_IW'(i);
      end
    end
  end

  // Hardware hit set takes priority over a simultaneous W1C
  always_comb begin
    prev_rd_d = CPURD;
    prev_ma_d = MA;
    rperr_d   = any_ev_c;
    slot_d    = any_ev_c ? win_idx_c : '0;
    hit_d     = (hit_q & ~(sts_we_c ? ICEDI[MAX_NSLOT-1:0] : '0)) | fire_c;
  end

  always_ff @(posedge CLK or negedge SYSRSOUTB) begin
    if (!SYSRSOUTB) begin
      prev_rd_q <= 1'b0;
      prev_ma_q <= '0;
      rperr_q   <= 1'b0;
      slot_q    <= '0;
      hit_q     <= '0;
    end else begin
      prev_rd_q <= prev_rd_d;
      prev_ma_q <= prev_ma_d;
      rperr_q   <= rperr_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
    end
  end

  assign RPERR    = rperr_q;
  assign PRTYSLOT = slot_q;

  // Host read mux, combinational on ICEIFA
  always_comb begin
    ICEDOPB = '0;
    sts_c   = '{armed: armed_c, hit: hit_q};
    if (ICEIFA == STS_A) ICEDOPB = HADR_W'(sts_c);
    for (int unsigned i = 0; i < MAX_NSLOT; i++) begin
      if (ICEIFA == reg_addr(BASEADR, ADR_OFS, i)) ICEDOPB = HADR_W'(adr_rd[i]);
      if (ICEIFA == reg_addr(BASEADR, CTL_OFS, i)) ICEDOPB = HADR_W'(ctl_rd[i]);
    end
  end

endmodule

// File: tb/tb_ierl78_prtyerr_seq.sv
// Self-checking bench for the parity-error injection sequencer; injection
// pulses are matched against a queue of expected (slot, cycle) entries.
module tb_ierl78_prtyerr_seq;

  localparam logic [31:0] BASE = 32'h0401_0000;
  localparam logic [31:0] STS  = BASE + 32'h20;

  logic        CLK;
  logic        SYSRSOUTB;
  logic [31:0] ICEIFA;
  logic [15:0] ICEDI;
  logic        ICEWR;
  logic [31:0] ICEDOPB;
  logic [15:0] MA;
  logic        CPURD;
  logic        SVMOD;
  logic        FCHRAM;
  logic        RPERR;
  logic [1:0]  PRTYSLOT;

  typedef struct {
    logic [1:0] slot;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  ierl78_prtyerr_seq #(.NSLOT(4), .BASEADR(BASE)) dut (
    .CLK       (CLK),
    .SYSRSOUTB (SYSRSOUTB),
    .ICEIFA    (ICEIFA),
    .ICEDI     (ICEDI),
    .ICEWR     (ICEWR),
    .ICEDOPB   (ICEDOPB),
    .MA        (MA),
    .CPURD     (CPURD),
    .SVMOD     (SVMOD),
    .FCHRAM    (FCHRAM),
    .RPERR     (RPERR),
    .PRTYSLOT  (PRTYSLOT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] adr_a(input int i);
    return BASE + 32'(4 * i);
  endfunction

  function automatic logic [31:0] ctl_a(input int i);
    return BASE + 32'h10 + 32'(4 * i);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [15:0] d);
    ICEIFA = a;
    ICEDI  = d;
    ICEWR  = 1'b1;
    step();
    ICEWR  = 1'b0;
  endtask

  task automatic host_rd(input logic [31:0] a, output logic [31:0] d);
    ICEIFA = a;
    #2;
    d = ICEDOPB;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] s);
    exp_q.push_back('{slot: s, cyc: cyc + 1});
  endtask

  // Single-cycle CPU read followed by idle cycles so the slot leaves FIRE
  task automatic cpu_rd(input logic [15:0] a, input logic fire, input logic [1:0] s);
    MA    = a;
    CPURD = 1'b1;
    if (fire) push_exp(s);
    step();
    CPURD = 1'b0;
    step();
    step();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (SYSRSOUTB === 1'b1 && RPERR === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL pulse_unexpected: RPERR=1 PRTYSLOT=%0d at cycle %0d, expected no pulse",
                   PRTYSLOT, cyc);
        end else begin
          e = exp_q.pop_front();
          if (PRTYSLOT !== e.slot || cyc != e.cyc)
            $display("FAIL pulse: slot %0d at cycle %0d, expected slot %0d at cycle %0d",
                     PRTYSLOT, cyc, e.slot, e.cyc);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_chk++;
    if (RPERR !== 1'b0 || PRTYSLOT !== 2'd0)
      $display("FAIL reset_out: RPERR=%b PRTYSLOT=%0d, expected 0/0", RPERR, PRTYSLOT);
    else n_pass++;
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL reset_sts: got %h expected 00000000", d);
    else n_pass++;
    host_wr(adr_a(0), 16'hF123);
    host_wr(ctl_a(0), 16'h0301);
    host_rd(adr_a(0), d);
    n_chk++;
    if (d !== 32'h0000_F123) $display("FAIL readback_adr0: got %h expected 0000f123", d);
    else n_pass++;
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0000_0301) $display("FAIL readback_ctl0: got %h expected 00000301", d);
    else n_pass++;
    // Reset asserted while a pulse is on RPERR
    MA    = 16'hF123;
    CPURD = 1'b1;
    step();
    n_chk++;
    if (RPERR !== 1'b1) $display("FAIL reset_prepulse: RPERR=%b expected 1", RPERR);
    else n_pass++;
    #1 SYSRSOUTB = 1'b0;
    #1;
    n_chk++;
    if (RPERR !== 1'b0) $display("FAIL reset_async: RPERR=%b expected 0", RPERR);
    else n_pass++;
    CPURD = 1'b0;
    host_rd(adr_a(0), d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL reset_adr0: got %h expected 00000000", d);
    else n_pass++;
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL reset_ctl0: got %h expected 00000000", d);
    else n_pass++;
    SYSRSOUTB = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    host_wr(adr_a(0), 16'hFE00);
    host_wr(ctl_a(0), 16'h0301);
    for (int i = 0; i < 4; i++) cpu_rd(16'hFE00, (i < 3), 2'd0);
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL oneshot_ctl0: got %h expected 00000000", d);
    else n_pass++;
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h1) $display("FAIL oneshot_sts: got %h expected 00000001", d);
    else n_pass++;
    host_wr(STS, 16'h000F);
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL sts_w1c: got %h expected 00000000", d);
    else n_pass++;
  endtask

  task automatic test_held_read();
    logic [31:0] d;
    host_wr(ctl_a(0), 16'h0501);
    MA    = 16'hFE00;
    CPURD = 1'b1;
    push_exp(2'd0);
    repeat (5) step();
    CPURD = 1'b0;
    repeat (2) step();
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0401) $display("FAIL held_ctl0: got %h expected 00000401", d);
    else n_pass++;
    SVMOD = 1'b1;
    CPURD = 1'b1;
    repeat (2) step();
    SVMOD = 1'b0;
    repeat (2) step();
    CPURD = 1'b0;
    repeat (2) step();
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0401) $display("FAIL svmod_ctl0: got %h expected 00000401", d);
    else n_pass++;
    FCHRAM = 1'b1;
    CPURD  = 1'b1;
    repeat (2) step();
    CPURD  = 1'b0;
    FCHRAM = 1'b0;
    repeat (2) step();
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0401) $display("FAIL fchram_ctl0: got %h expected 00000401", d);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [31:0] d;
    host_wr(ctl_a(0), 16'h0000);
    host_wr(adr_a(1), 16'h1000);
    host_wr(adr_a(2), 16'h1000);
    host_wr(ctl_a(1), 16'h0003);
    host_wr(ctl_a(2), 16'h0003);
    host_wr(STS, 16'h000F);
    cpu_rd(16'h1000, 1'b1, 2'd1);
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h62) $display("FAIL arb_sts1: got %h expected 00000062", d);
    else n_pass++;
    host_wr(ctl_a(1), 16'h0000);
    cpu_rd(16'h1000, 1'b1, 2'd2);
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h46) $display("FAIL arb_sts2: got %h expected 00000046", d);
    else n_pass++;
    host_rd(ctl_a(2), d);
    n_chk++;
    if (d !== 32'h0003) $display("FAIL cont_ctl2: got %h expected 00000003", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    host_wr(adr_a(3), 16'h2000);
    host_wr(ctl_a(3), 16'h0003);
    MA    = 16'h1000;
    CPURD = 1'b1;
    push_exp(2'd2);
    step();
    MA = 16'h2000;
    push_exp(2'd3);
    step();
    CPURD = 1'b0;
    repeat (2) step();
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'hCE) $display("FAIL b2b_sts: got %h expected 000000ce", d);
    else n_pass++;
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    host_wr(ctl_a(2), 16'h0000);
    host_wr(ctl_a(3), 16'h0000);
    host_wr(adr_a(0), 16'h3000);
    host_wr(ctl_a(0), 16'h0301);
    host_wr(STS, 16'h000F);
    // W1C lands in the FIRE cycle
    MA    = 16'h3000;
    CPURD = 1'b1;
    push_exp(2'd0);
    step();
    CPURD = 1'b0;
    host_wr(STS, 16'h0001);
    step();
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h11) $display("FAIL w1c_vs_set: got %h expected 00000011", d);
    else n_pass++;
    // CTL write lands in the FIRE cycle
    MA    = 16'h3000;
    CPURD = 1'b1;
    push_exp(2'd0);
    step();
    CPURD = 1'b0;
    host_wr(ctl_a(0), 16'h0501);
    step();
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0501) $display("FAIL ctl_vs_fire: got %h expected 00000501", d);
    else n_pass++;
    host_wr(adr_a(0), 16'h3002);
    cpu_rd(16'h3000, 1'b0, 2'd0);
    cpu_rd(16'h3002, 1'b1, 2'd0);
    host_rd(ctl_a(0), d);
    n_chk++;
    if (d !== 32'h0401) $display("FAIL adr_rearm_ctl0: got %h expected 00000401", d);
    else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] adr_exp [4];
    logic [31:0] ctl_exp [4];
    adr_exp = '{32'h3002, 32'h1000, 32'h1000, 32'h2000};
    ctl_exp = '{32'h0401, 32'h0000, 32'h0000, 32'h0000};
    host_wr(STS, 16'h000F);
    host_wr(BASE + 32'h30, 16'hFFFF);
    host_wr(BASE + 32'h24, 16'hFFFF);
    host_wr(BASE + 32'h34, 16'hFFFF);
    host_rd(BASE + 32'h30, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL decode_30: got %h expected 00000000", d);
    else n_pass++;
    host_rd(BASE + 32'h24, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL decode_slot5: got %h expected 00000000", d);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      host_rd(adr_a(i), d);
      n_chk++;
      if (d !== adr_exp[i]) $display("FAIL decode_adr%0d: got %h expected %h", i, d, adr_exp[i]);
      else n_pass++;
      host_rd(ctl_a(i), d);
      n_chk++;
      if (d !== ctl_exp[i]) $display("FAIL decode_ctl%0d: got %h expected %h", i, d, ctl_exp[i]);
      else n_pass++;
    end
    host_rd(STS, d);
    n_chk++;
    if (d !== 32'h10) $display("FAIL decode_sts: got %h expected 00000010", d);
    else n_pass++;
  endtask

  initial begin
    SYSRSOUTB = 1'b0;
    ICEIFA    = '0;
    ICEDI     = '0;
    ICEWR     = 1'b0;
    MA        = '0;
    CPURD     = 1'b0;
    SVMOD     = 1'b0;
    FCHRAM    = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge CLK);
    #1 SYSRSOUTB = 1'b1;
    step();
    test_reset();
    test_one_shot();
    test_held_read();
    test_arbitration();
    test_back_to_back();
    test_collisions();
    test_decode();
    repeat (4) step();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d pulses missing, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
